mc_controller: RTL and testbench

Multi-cycle control unit for the RV32I core, replacing single-cycle decode-only control with an FSM that sequences fetch, decode, execute, memory and write-back. It owns the memory request/acknowledge handshake, drives PC, IR, register-file and ALU selects, and traps on illegal encodings or memory timeouts. It sits between the instruction register, the datapath muxes and the unified memory port.

---
 rtl/mc_controller_pkg.sv | 94 +++++++++
 rtl/mc_controller_if.sv | 19 +
 rtl/mc_controller_instr_decode.sv | 72 +++++++
 rtl/mc_controller.sv | 196 +++++++++++++++++++
 tb/tb_mc_controller.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Imported by the decoder and the sequencing FSM.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_ROR  = 4'd9,
    ALU_ROL  = 4'd10,
    ALU_SLT  = 4'd11,
    ALU_SLTU = 4'd12
  } alu_ops_t;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR
  } instr_class_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_PC4 = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_FETCH   = 2'b10;
  localparam logic [1:0] CAUSE_DATA    = 2'b11;

  typedef struct packed {
    instr_class_t cls;
    alu_ops_t     alu_op;
    logic [2:0]   imm_sel;
    logic [1:0]   mem_size;
    logic         mem_unsigned;
    logic         illegal;
  } decode_t;

  // R-type and I-type arithmetic share the funct3 mapping; alt selects SUB/SRA.
  function automatic alu_ops_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Unified memory port handshake between the control unit and memory.
interface mc_controller_if;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        mem_ack;
  logic [31:0] mem_rdata_instr;

  modport master (
    output mem_req, mem_we, mem_size, mem_unsigned,
    input  mem_ack, mem_rdata_instr
  );

  modport slave (
    input  mem_req, mem_we, mem_size, mem_unsigned,
    output mem_ack, mem_rdata_instr
  );
endinterface

// File: rtl/mc_controller_instr_decode.sv
// Combinational RV32I classifier: instruction class, ALU op, immediate
// format, memory access size/sign and illegal-encoding detection.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec = '{cls: CLS_ALU, alu_op: ALU_ADD, imm_sel: IMM_I,
            mem_size: MEM_WORD, mem_unsigned: 1'b0, illegal: 1'b1};
    case (opcode)
      OP_OP: begin
        dec.alu_op  = alu_from_funct3(funct3, funct7[5]);
        dec.illegal = !((funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_IMM: begin
        // Only the shift-immediates carry funct7; the rest use those bits as immediate.
        dec.alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
        case (funct3)
          3'b001:  dec.illegal = (funct7 != F7_BASE);
          3'b101:  dec.illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
          default: dec.illegal = 1'b0;
        endcase
      end
      OP_LUI, OP_AUIPC: begin
        dec.imm_sel = IMM_U;
        dec.illegal = 1'b0;
      end
      OP_LOAD: begin
        dec.cls          = CLS_LOAD;
        dec.mem_size     = funct3[1:0];
        dec.mem_unsigned = funct3[2];
        dec.illegal      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        dec.cls      = CLS_STORE;
        dec.imm_sel  = IMM_S;
        dec.mem_size = funct3[1:0];
        dec.illegal  = (funct3 >= 3'b011);
      end
      OP_BRANCH: begin
        dec.cls     = CLS_BRANCH;
        dec.imm_sel = IMM_B;
        dec.illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        dec.cls     = CLS_JAL;
        dec.imm_sel = IMM_J;
        dec.illegal = 1'b0;
      end
      OP_JALR: begin
        dec.cls     = CLS_JALR;
        dec.illegal = (funct3 != 3'b000);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb, owns the
// memory handshake with a wait-cycle timeout, and traps stickily on faults.
module mc_controller
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ALUOP_W        = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instr,
  input  logic                br_cond,
  mc_controller_if.master     mem,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [2:0]          cmp_op,
  output logic [2:0]          imm_sel,
  output logic                reg_we,
  output logic [1:0]          wb_sel,
  output logic                retire,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  localparam int              CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  ctrl_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       cause, cause_next;
  decode_t          dec;
  alu_ops_t         op_sel;
  logic [1:0]       alu_a_sel, alu_b_sel;
  logic             timeout_hit;
  logic             unused_rdata;

  instr_decode u_decode (
    .instr (instr),
    .dec   (dec)
  );

  assign unused_rdata = ^mem.mem_rdata_instr;
  // The counter value before increment equals LIMIT on the last allowed wait cycle.
  assign timeout_hit  = TIMEOUT_EN && (cnt == CNT_LIMIT);
  assign alu_a_sel    = (instr[6:0] == OP_LUI)   ? SRC_A_ZERO :
                        (instr[6:0] == OP_AUIPC) ? SRC_A_PC   : SRC_A_RS1;
  assign alu_b_sel    = (instr[6:0] == OP_OP)    ? SRC_B_RS2  : SRC_B_IMM;

  // reset is active-low; release is expected to be synchronised upstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_FETCH;
      cnt   <= '0;
      cause <= CAUSE_NONE;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cause <= cause_next;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause;
    case (state)
      ST_FETCH: begin
        if (mem.mem_ack)      state_next = ST_DECODE;
        else if (timeout_hit) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_FETCH;
        end
      end
      ST_DECODE: begin
        if (dec.illegal) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (dec.cls)
          CLS_ALU:             state_next = ST_WB;
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          default:             state_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem.mem_ack)      state_next = (dec.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        else if (timeout_hit) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_DATA;
        end
      end
      ST_WB:   state_next = ST_FETCH;
      default: state_next = ST_TRAP;
    endcase

    // Counter restarts on every state entry and only runs while a request waits.
    if (state_next != state)
      cnt_next = '0;
    else if ((state == ST_FETCH) || (state == ST_MEM))
      cnt_next = cnt + CNT_W'(1);
    else
      cnt_next = '0;
  end

  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_size     = MEM_WORD;
    mem.mem_unsigned = 1'b0;
    ir_we            = 1'b0;
    pc_we            = 1'b0;
    pc_src           = PC_PLUS4;
    alu_src_a        = SRC_A_RS1;
    alu_src_b        = SRC_B_RS2;
    op_sel           = ALU_ADD;
    cmp_op           = 3'b000;
    imm_sel          = IMM_I;
    reg_we           = 1'b0;
    wb_sel           = WB_PC4;
    retire           = 1'b0;
    // Gating on reset lets mem_req fall the instant reset asserts.
    if (reset) begin
      case (state)
        ST_FETCH: begin
          mem.mem_req = 1'b1;
          ir_we       = mem.mem_ack;
        end
        ST_EXEC: begin
          imm_sel = dec.imm_sel;
          case (dec.cls)
            CLS_ALU: begin
              alu_src_a = alu_a_sel;
              alu_src_b = alu_b_sel;
              op_sel    = dec.alu_op;
            end
            CLS_LOAD, CLS_STORE: alu_src_b = SRC_B_IMM;
            CLS_BRANCH: begin
              cmp_op = instr[14:12];
              pc_we  = 1'b1;
              pc_src = br_cond ? PC_IMM : PC_PLUS4;
              retire = 1'b1;
            end
            default: begin
              alu_src_b = SRC_B_IMM;
              reg_we    = 1'b1;
              wb_sel    = WB_PC4;
              pc_we     = 1'b1;
              pc_src    = (dec.cls == CLS_JAL) ? PC_IMM : PC_JALR;
              retire    = 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          alu_src_b        = SRC_B_IMM;
          imm_sel          = dec.imm_sel;
          mem.mem_req      = 1'b1;
          mem.mem_we       = (dec.cls == CLS_STORE);
          mem.mem_size     = dec.mem_size;
          mem.mem_unsigned = (dec.cls == CLS_LOAD) && dec.mem_unsigned;
          if (dec.cls == CLS_STORE) begin
            pc_we  = mem.mem_ack;
            retire = mem.mem_ack;
          end
        end
        ST_WB: begin
          reg_we  = 1'b1;
          pc_we   = 1'b1;
          retire  = 1'b1;
          imm_sel = dec.imm_sel;
          if (dec.cls == CLS_LOAD) begin
            wb_sel = WB_MEM;
          end else begin
            wb_sel    = WB_ALU;
            alu_src_a = alu_a_sel;
            alu_src_b = alu_b_sel;
            op_sel    = dec.alu_op;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_op     = ALUOP_W'(op_sel);
  assign trap       = (state == ST_TRAP);
  assign trap_cause = cause;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller with a 4-cycle memory timeout.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        br_cond = 1'b0;
  logic        ir_we, pc_we, reg_we, retire, trap;
  logic [1:0]  pc_src, alu_src_a, alu_src_b, wb_sel, trap_cause;
  logic [3:0]  alu_op;
  logic [2:0]  cmp_op, imm_sel;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0, retire_cnt = 0, reg_we_cnt = 0, mem_req_cnt = 0;

  mc_controller_if mem ();

  mc_controller #(.TIMEOUT_CYCLES(4), .ALUOP_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .br_cond    (br_cond),
    .mem        (mem),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .cmp_op     (cmp_op),
    .imm_sel    (imm_sel),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .retire     (retire),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  // Per-cycle activity counters, sampled late in the low phase.
  always begin
    @(negedge clk);
    #3;
    cyc_cnt++;
    if (retire)      retire_cnt++;
    if (reg_we)      reg_we_cnt++;
    if (mem.mem_req) mem_req_cnt++;
  end

  task automatic next_cycle;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    mem.mem_ack = 1'b0;
    br_cond = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    mem.mem_ack = 1'b0;
    mem.mem_rdata_instr = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem.mem_req, mem.mem_we, ir_we, pc_we, reg_we, retire, trap} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes got=%b exp=%b",
               {mem.mem_req, mem.mem_we, ir_we, pc_we, reg_we, retire, trap}, 7'b0);
    end
    checks++;
    if ({mem.mem_size, alu_op, trap_cause} !== {2'b10, 4'd1, 2'b00}) begin
      failures++;
      $display("[TB] FAIL reset_values got=%b exp=%b", {mem.mem_size, alu_op, trap_cause},
               {2'b10, 4'd1, 2'b00});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({mem.mem_req, mem.mem_we, mem.mem_size} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL reset_first_fetch got=%b exp=%b",
               {mem.mem_req, mem.mem_we, mem.mem_size}, 4'b1010);
    end
  endtask

  task automatic test_add;
    int c0, r0;
    c0 = cyc_cnt; r0 = retire_cnt;
    instr = 32'h002081B3;
    mem.mem_ack = 1'b1;
    #1;
    checks++;
    if ({mem.mem_req, ir_we, mem.mem_we, mem.mem_size} !== 5'b11010) begin
      failures++;
      $display("[TB] FAIL add_fetch got=%b exp=%b", {mem.mem_req, ir_we, mem.mem_we, mem.mem_size}, 5'b11010);
    end
    next_cycle; mem.mem_ack = 1'b0; #1;
    checks++;
    if ({mem.mem_req, ir_we, reg_we, pc_we, retire} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL add_decode got=%b exp=%b", {mem.mem_req, ir_we, reg_we, pc_we, retire}, 5'b0);
    end
    next_cycle; #1;
    checks++;
    if ({alu_op, alu_src_a, alu_src_b, reg_we, retire} !== {4'd1, 2'b00, 2'b00, 2'b00}) begin
      failures++;
      $display("[TB] FAIL add_exec got=%b exp=%b", {alu_op, alu_src_a, alu_src_b, reg_we, retire},
               {4'd1, 2'b00, 2'b00, 2'b00});
    end
    next_cycle; #1;
    checks++;
    if ({reg_we, wb_sel, pc_we, pc_src, retire, alu_op} !== {1'b1, 2'b01, 1'b1, 2'b00, 1'b1, 4'd1}) begin
      failures++;
      $display("[TB] FAIL add_wb got=%b exp=%b", {reg_we, wb_sel, pc_we, pc_src, retire, alu_op},
               {1'b1, 2'b01, 1'b1, 2'b00, 1'b1, 4'd1});
    end
    next_cycle; #1;
    checks++;
    if (mem.mem_req !== 1'b1 || (cyc_cnt - c0) != 4 || (retire_cnt - r0) != 1) begin
      failures++;
      $display("[TB] FAIL add_cpi got req=%b cycles=%0d retires=%0d exp req=1 cycles=4 retires=1",
               mem.mem_req, cyc_cnt - c0, retire_cnt - r0);
    end
  endtask

  task automatic test_lhu;
    int c0;
    c0 = cyc_cnt;
    instr = 32'h0040D283;
    mem.mem_ack = 1'b1;
    #1;
    next_cycle; mem.mem_ack = 1'b0;
    next_cycle; #1;
    checks++;
    if ({alu_src_a, alu_src_b, alu_op, imm_sel} !== {2'b00, 2'b01, 4'd1, 3'd0}) begin
      failures++;
      $display("[TB] FAIL lhu_exec got=%b exp=%b", {alu_src_a, alu_src_b, alu_op, imm_sel},
               {2'b00, 2'b01, 4'd1, 3'd0});
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle;
      mem.mem_ack = (i == 2);
      #1;
      checks++;
      if ({mem.mem_req, mem.mem_we, mem.mem_size, mem.mem_unsigned, reg_we} !== 6'b100110) begin
        failures++;
        $display("[TB] FAIL lhu_mem%0d got=%b exp=%b", i,
                 {mem.mem_req, mem.mem_we, mem.mem_size, mem.mem_unsigned, reg_we}, 6'b100110);
      end
    end
    next_cycle; mem.mem_ack = 1'b0; #1;
    checks++;
    if ({reg_we, wb_sel, pc_we, pc_src, retire} !== {1'b1, 2'b10, 1'b1, 2'b00, 1'b1}) begin
      failures++;
      $display("[TB] FAIL lhu_wb got=%b exp=%b", {reg_we, wb_sel, pc_we, pc_src, retire},
               {1'b1, 2'b10, 1'b1, 2'b00, 1'b1});
    end
    next_cycle; #1;
    checks++;
    if (mem.mem_req !== 1'b1 || mem.mem_we !== 1'b0 || (cyc_cnt - c0) != 7) begin
      failures++;
      $display("[TB] FAIL lhu_cpi got req=%b we=%b cycles=%0d exp req=1 we=0 cycles=7",
               mem.mem_req, mem.mem_we, cyc_cnt - c0);
    end
  endtask

  task automatic test_branch;
    int w0;
    logic [1:0] exp_src;
    w0 = reg_we_cnt;
    instr = 32'h00208463;
    for (int taken = 1; taken >= 0; taken--) begin
      int c0;
      c0 = cyc_cnt;
      exp_src = (taken == 1) ? 2'b01 : 2'b00;
      mem.mem_ack = 1'b1;
      #1;
      next_cycle; mem.mem_ack = 1'b0;
      next_cycle; br_cond = (taken == 1); #1;
      checks++;
      if ({pc_we, pc_src, retire, reg_we, cmp_op} !== {1'b1, exp_src, 1'b1, 1'b0, 3'b000}) begin
        failures++;
        $display("[TB] FAIL branch_exec_taken%0d got=%b exp=%b", taken,
                 {pc_we, pc_src, retire, reg_we, cmp_op}, {1'b1, exp_src, 1'b1, 1'b0, 3'b000});
      end
      next_cycle; br_cond = 1'b0; #1;
      checks++;
      if (mem.mem_req !== 1'b1 || (cyc_cnt - c0) != 3) begin
        failures++;
        $display("[TB] FAIL branch_cpi_taken%0d got req=%b cycles=%0d exp req=1 cycles=3",
                 taken, mem.mem_req, cyc_cnt - c0);
      end
    end
    checks++;
    if ((reg_we_cnt - w0) != 0) begin
      failures++;
      $display("[TB] FAIL branch_no_reg_we got=%0d exp=0", reg_we_cnt - w0);
    end
  endtask

  task automatic test_store;
    int c0;
    c0 = cyc_cnt;
    instr = 32'h0020A423;
    mem.mem_ack = 1'b1;
    #1;
    next_cycle; mem.mem_ack = 1'b0;
    next_cycle; #1;
    checks++;
    if ({alu_src_b, alu_op, imm_sel} !== {2'b01, 4'd1, 3'd1}) begin
      failures++;
      $display("[TB] FAIL store_exec got=%b exp=%b", {alu_src_b, alu_op, imm_sel}, {2'b01, 4'd1, 3'd1});
    end
    next_cycle; mem.mem_ack = 1'b1; #1;
    checks++;
    if ({mem.mem_req, mem.mem_we, mem.mem_size, pc_we, retire, reg_we} !== 7'b1110110) begin
      failures++;
      $display("[TB] FAIL store_mem got=%b exp=%b",
               {mem.mem_req, mem.mem_we, mem.mem_size, pc_we, retire, reg_we}, 7'b1110110);
    end
    next_cycle; #1;
    checks++;
    if (mem.mem_req !== 1'b1 || mem.mem_we !== 1'b0 || (cyc_cnt - c0) != 4) begin
      failures++;
      $display("[TB] FAIL store_cpi got req=%b we=%b cycles=%0d exp req=1 we=0 cycles=4",
               mem.mem_req, mem.mem_we, cyc_cnt - c0);
    end
    // Second store is interrupted by reset while waiting in MEM.
    next_cycle; mem.mem_ack = 1'b0;
    next_cycle;
    next_cycle; #1;
    checks++;
    if ({mem.mem_req, mem.mem_we} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL store_wait got=%b exp=%b", {mem.mem_req, mem.mem_we}, 2'b11);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({mem.mem_req, mem.mem_we} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL store_reset_drop got=%b exp=%b", {mem.mem_req, mem.mem_we}, 2'b00);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({mem.mem_req, mem.mem_we, mem.mem_size, trap} !== 5'b10100) begin
      failures++;
      $display("[TB] FAIL store_reset_refetch got=%b exp=%b", {mem.mem_req, mem.mem_we, mem.mem_size, trap}, 5'b10100);
    end
  endtask

  task automatic test_illegal(input logic [31:0] word, input string name);
    int m0;
    instr = word;
    mem.mem_ack = 1'b1;
    #1;
    next_cycle; mem.mem_ack = 1'b0; #1;
    checks++;
    if ({trap, retire, mem.mem_req} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL %s_decode got=%b exp=%b", name, {trap, retire, mem.mem_req}, 3'b000);
    end
    next_cycle; #1;
    checks++;
    if ({trap, trap_cause, mem.mem_req} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL %s_trap got=%b exp=%b", name, {trap, trap_cause, mem.mem_req}, 4'b1010);
    end
    m0 = mem_req_cnt;
    mem.mem_ack = 1'b1;
    repeat (5) next_cycle;
    #1;
    checks++;
    if ((mem_req_cnt - m0) != 0 || {trap, trap_cause, ir_we} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL %s_sticky got reqs=%0d flags=%b exp reqs=0 flags=%b",
               name, mem_req_cnt - m0, {trap, trap_cause, ir_we}, 4'b1010);
    end
    do_reset;
    checks++;
    if ({trap, trap_cause, mem.mem_req} !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL %s_cleared got=%b exp=%b", name, {trap, trap_cause, mem.mem_req}, 4'b0001);
    end
  endtask

  task automatic test_fetch_timeout;
    mem.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({mem.mem_req, trap} !== 2'b10) begin
        failures++;
        $display("[TB] FAIL fetch_wait%0d got=%b exp=%b", i, {mem.mem_req, trap}, 2'b10);
      end
      next_cycle;
    end
    #1;
    checks++;
    if ({mem.mem_req, trap, trap_cause} !== 4'b0110) begin
      failures++;
      $display("[TB] FAIL fetch_timeout got=%b exp=%b", {mem.mem_req, trap, trap_cause}, 4'b0110);
    end
    do_reset;
    instr = 32'h002081B3;
    repeat (3) next_cycle;
    mem.mem_ack = 1'b1;
    #1;
    checks++;
    if ({mem.mem_req, ir_we} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL fetch_ack_at_limit got=%b exp=%b", {mem.mem_req, ir_we}, 2'b11);
    end
    next_cycle; mem.mem_ack = 1'b0; #1;
    checks++;
    if ({trap, trap_cause, mem.mem_req} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL fetch_ack_wins got=%b exp=%b", {trap, trap_cause, mem.mem_req}, 4'b0000);
    end
    do_reset;
  endtask

  task automatic test_data_timeout;
    instr = 32'h0040D283;
    mem.mem_ack = 1'b1;
    #1;
    next_cycle; mem.mem_ack = 1'b0;
    next_cycle;
    for (int i = 0; i < 4; i++) begin
      next_cycle; #1;
      checks++;
      if ({mem.mem_req, mem.mem_size, trap} !== 4'b1010) begin
        failures++;
        $display("[TB] FAIL data_wait%0d got=%b exp=%b", i, {mem.mem_req, mem.mem_size, trap}, 4'b1010);
      end
    end
    next_cycle; #1;
    checks++;
    if ({mem.mem_req, trap, trap_cause, reg_we} !== 5'b01110) begin
      failures++;
      $display("[TB] FAIL data_timeout got=%b exp=%b", {mem.mem_req, trap, trap_cause, reg_we}, 5'b01110);
    end
  endtask

  initial begin
    $display("[TB] mc_controller directed tests start");
    test_reset;
    test_add;
    test_lhu;
    test_branch;
    test_store;
    test_illegal(32'h0000007F, "illegal_opcode");
    test_illegal(32'h4020F1B3, "illegal_funct7");
    test_fetch_timeout;
    test_data_timeout;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
